// File: rtl/dcm_ctl.sv
// dcm_ctl: DCM bring-up sequencer, lock/status supervisor and single-step
// phase-shift handshake controller. Runs on the DCM input clock (also PSCLK).
// Ports: CLK, RST_n (async, active low); DCM_RST, DCM_LOCKED, DCM_STATUS,
// DCM_PSEN, DCM_PSINCDEC, DCM_PSDONE to/from the DCM; PS_REQ/PS_INC/PS_ACK/
// PS_ERR phase-shift requester side; SYS_RST_n, READY, RETRY_CNT status.
module dcm_ctl #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1023,
  parameter int unsigned PS_TIMEOUT    = 255
) (
  input  logic       CLK,
  input  logic       RST_n,
  output logic       DCM_RST,
  input  logic       DCM_LOCKED,
  input  logic       DCM_STATUS,
  output logic       DCM_PSEN,
  output logic       DCM_PSINCDEC,
  input  logic       DCM_PSDONE,
  input  logic       PS_REQ,
  input  logic       PS_INC,
  output logic       PS_ACK,
  output logic       PS_ERR,
  output logic       SYS_RST_n,
  output logic       READY,
  output logic [3:0] RETRY_CNT
);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_PS_WAIT
  } state_t;

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] PS_LAST     = 16'(PS_TIMEOUT);

  state_t      state;
  logic [15:0] cnt;
  logic        locked_m, locked_s;
  logic        status_m, status_s;
  logic        healthy;
  logic        go_reset;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
      status_m <= 1'b0;
      status_s <= 1'b0;
    end else begin
      locked_m <= DCM_LOCKED;
      locked_s <= locked_m;
      status_m <= DCM_STATUS;
      status_s <= status_m;
    end
  end

  assign healthy = locked_s & ~status_s;

  // Every non-RST_n entry to RESET funnels through this one flag so the
  // retry count and reset outputs are updated in a single place.
  always_comb begin
    go_reset = 1'b0;
    case (state)
      S_WAIT_LOCK:                go_reset = !locked_s && (cnt == LOCK_LAST);
      S_STABLE, S_RUN, S_PS_WAIT: go_reset = !healthy;
      default:                    go_reset = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state        <= S_RESET;
      cnt          <= '0;
      DCM_RST      <= 1'b1;
      SYS_RST_n    <= 1'b0;
      READY        <= 1'b0;
      DCM_PSEN     <= 1'b0;
      DCM_PSINCDEC <= 1'b0;
      PS_ACK       <= 1'b0;
      PS_ERR       <= 1'b0;
      RETRY_CNT    <= '0;
    end else begin
      DCM_PSEN <= 1'b0;
      PS_ACK   <= 1'b0;
      if (go_reset) begin
        state     <= S_RESET;
        cnt       <= '0;
        DCM_RST   <= 1'b1;
        SYS_RST_n <= 1'b0;
        READY     <= 1'b0;
        if (RETRY_CNT != '1) RETRY_CNT <= RETRY_CNT + 4'd1;
      end else begin
        case (state)
          S_RESET: begin
            if (cnt == RST_LAST) begin
              state   <= S_WAIT_LOCK;
              cnt     <= '0;
              DCM_RST <= 1'b0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_WAIT_LOCK: begin
            if (locked_s) begin
              state <= S_STABLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_STABLE: begin
            if (cnt == STABLE_LAST) begin
              state <= S_RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_RUN: begin
            SYS_RST_n <= 1'b1;
            READY     <= 1'b1;
            // PS_ACK gates the request so a level held one cycle past the
            // acknowledge is not taken as a new shift.
            if (PS_REQ && !PS_ACK) begin
              DCM_PSEN     <= 1'b1;
              DCM_PSINCDEC <= PS_INC;
              state        <= S_PS_WAIT;
              cnt          <= '0;
            end
          end
          S_PS_WAIT: begin
            if (DCM_PSDONE) begin
              PS_ACK <= 1'b1;
              state  <= S_RUN;
            end else if (cnt == PS_LAST) begin
              PS_ERR <= 1'b1;
              PS_ACK <= 1'b1;
              state  <= S_RUN;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: state <= S_RESET;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcm_ctl.sv
module tb_dcm_ctl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 16;
  localparam int PS_TIMEOUT    = 8;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       DCM_RST;
  logic       DCM_LOCKED = 1'b0;
  logic       DCM_STATUS = 1'b0;
  logic       DCM_PSEN;
  logic       DCM_PSINCDEC;
  logic       DCM_PSDONE = 1'b0;
  logic       PS_REQ = 1'b0;
  logic       PS_INC = 1'b0;
  logic       PS_ACK;
  logic       PS_ERR;
  logic       SYS_RST_n;
  logic       READY;
  logic [3:0] RETRY_CNT;

  dcm_ctl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .PS_TIMEOUT   (PS_TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .DCM_RST     (DCM_RST),
    .DCM_LOCKED  (DCM_LOCKED),
    .DCM_STATUS  (DCM_STATUS),
    .DCM_PSEN    (DCM_PSEN),
    .DCM_PSINCDEC(DCM_PSINCDEC),
    .DCM_PSDONE  (DCM_PSDONE),
    .PS_REQ      (PS_REQ),
    .PS_INC      (PS_INC),
    .PS_ACK      (PS_ACK),
    .PS_ERR      (PS_ERR),
    .SYS_RST_n   (SYS_RST_n),
    .READY       (READY),
    .RETRY_CNT   (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  // Number of rising edges so far; read on the falling edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    sb_val[$];
  string sb_tag[$];
  bit    err_model = 1'b0;

  int r, t, g, l0, pe, drop, prev, f;
  bit ack_seen;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int val);
    sb_tag.push_back(tag);
    sb_val.push_back(val);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string tg;
    int    v;
    if (sb_val.size() == 0) begin
      chk("sb_underflow", 32'(sb_val.size()), 32'd1);
    end else begin
      tg = sb_tag.pop_front();
      v  = sb_val.pop_front();
      chk(tg, obs, 32'(v));
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return DCM_RST;
      1:       return SYS_RST_n;
      2:       return DCM_PSEN;
      default: return PS_ACK;
    endcase
  endfunction

  task automatic wait_lvl(input int which, input logic lvl, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (sel(which) === lvl) begin
        at = cyc;
        return;
      end
      tick();
    end
  endtask

  // DCM side of a shift: PSDONE is sampled done_delay edges after the PSEN
  // edge (0 = never returned).
  task automatic finish_shift(input int pen, input int done_delay);
    int  exp_lat;
    int  a;
    bit  timed_out;
    timed_out = (done_delay == 0) || (done_delay > PS_TIMEOUT + 1);
    exp_lat   = timed_out ? PS_TIMEOUT + 1 : done_delay;
    if (timed_out) err_model = 1'b1;
    expect_val("ps_ack_lat", exp_lat);
    expect_val("ps_err", int'(err_model));
    a = -1;
    for (int k = 0; k < 30; k++) begin
      if (PS_ACK === 1'b1) begin
        a = cyc;
        break;
      end
      DCM_PSDONE = (done_delay != 0) && (cyc == pen + done_delay - 1);
      tick();
    end
    DCM_PSDONE = 1'b0;
    PS_REQ     = 1'b0;
    pop_chk((a < 0) ? -1 : a - pen);
    tick();
    chk("ps_ack_width", 32'(PS_ACK), 32'd0);
    pop_chk(32'(PS_ERR));
    chk("ready_after_ps", 32'(READY), 32'd1);
  endtask

  task automatic do_shift(input logic inc, input int done_delay);
    int q0, p;
    PS_INC = inc;
    PS_REQ = 1'b1;
    q0 = cyc;
    expect_val("psen_lat", 1);
    expect_val("psincdec", int'(inc));
    wait_lvl(2, 1'b1, 10, p);
    pop_chk((p < 0) ? -1 : p - q0);
    pop_chk(32'(DCM_PSINCDEC));
    tick();
    chk("psen_width", 32'(DCM_PSEN), 32'd0);
    finish_shift(p, done_delay);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // Reset values
    RST_n = 1'b0;
    repeat (3) tick();
    chk("rst_dcm_rst",   32'(DCM_RST),      32'd1);
    chk("rst_sys_rst_n", 32'(SYS_RST_n),    32'd0);
    chk("rst_ready",     32'(READY),        32'd0);
    chk("rst_psen",      32'(DCM_PSEN),     32'd0);
    chk("rst_psincdec",  32'(DCM_PSINCDEC), 32'd0);
    chk("rst_ps_ack",    32'(PS_ACK),       32'd0);
    chk("rst_ps_err",    32'(PS_ERR),       32'd0);
    chk("rst_retry",     32'(RETRY_CNT),    32'd0);

    // Clean bring-up
    RST_n = 1'b1;
    r = cyc;
    expect_val("dcm_rst_width", RST_CYCLES);
    wait_lvl(0, 1'b0, 20, t);
    pop_chk((t < 0) ? -1 : t - r);
    while (cyc < r + 20) tick();
    DCM_LOCKED = 1'b1;
    l0 = cyc;
    // counted from the first edge that samples LOCKED
    expect_val("release_lat", STABLE_CYCLES + 3);
    wait_lvl(1, 1'b1, 80, t);
    pop_chk((t < 0) ? -1 : t - (l0 + 1));
    chk("up_ready",   32'(READY),     32'd1);
    chk("up_retry",   32'(RETRY_CNT), 32'd0);
    chk("up_dcm_rst", 32'(DCM_RST),   32'd0);

    // Phase shifts
    do_shift(1'b1, 5);
    do_shift(1'b0, 5);
    repeat (5) tick();
    chk("psincdec_hold", 32'(DCM_PSINCDEC), 32'd0);
    do_shift(1'b1, PS_TIMEOUT + 1);   // PSDONE on the timeout edge
    do_shift(1'b0, 0);                // never answered
    do_shift(1'b1, 3);                // PS_ERR must stay set

    // Lock loss while waiting for PSDONE
    PS_INC = 1'b1;
    PS_REQ = 1'b1;
    wait_lvl(2, 1'b1, 10, pe);
    chk("loss_psen_seen", 32'(pe >= 0), 32'd1);
    tick();
    tick();
    DCM_LOCKED = 1'b0;
    drop = cyc;
    expect_val("loss_lat", 3);
    ack_seen = 1'b0;
    t = -1;
    for (int k = 0; k < 12; k++) begin
      if (PS_ACK === 1'b1) ack_seen = 1'b1;
      if (t < 0 && SYS_RST_n === 1'b0) t = cyc;
      tick();
    end
    pop_chk((t < 0) ? -1 : t - drop);
    chk("loss_no_ack", 32'(ack_seen),  32'd0);
    chk("loss_retry",  32'(RETRY_CNT), 32'd1);
    chk("loss_ready",  32'(READY),     32'd0);
    DCM_LOCKED = 1'b1;
    wait_lvl(1, 1'b1, 80, t);
    chk("relock_release", 32'(t >= 0), 32'd1);
    wait_lvl(2, 1'b1, 3, pe);
    chk("relock_psen", 32'(pe >= 0), 32'd1);
    chk("relock_psincdec", 32'(DCM_PSINCDEC), 32'd1);
    tick();
    finish_shift(pe, 4);

    // Asynchronous reset mid-operation
    tick();
    #2 RST_n = 1'b0;
    #1;
    err_model = 1'b0;
    chk("arst_dcm_rst",   32'(DCM_RST),      32'd1);
    chk("arst_sys_rst_n", 32'(SYS_RST_n),    32'd0);
    chk("arst_ready",     32'(READY),        32'd0);
    chk("arst_ps_err",    32'(PS_ERR),       32'd0);
    chk("arst_retry",     32'(RETRY_CNT),    32'd0);
    chk("arst_psincdec",  32'(DCM_PSINCDEC), 32'd0);
    tick();
    tick();

    // Lock glitch during the stable window (LOCKED already high)
    RST_n = 1'b1;
    r = cyc;
    while (cyc < r + 12) tick();
    g = cyc;
    DCM_LOCKED = 1'b0;
    repeat (3) tick();
    DCM_LOCKED = 1'b1;
    // 3 edges to reach RESET, RST_CYCLES there, one edge to STABLE,
    // then a full window plus one registered edge
    expect_val("glitch_release", 3 + RST_CYCLES + 1 + STABLE_CYCLES + 1);
    wait_lvl(1, 1'b1, 80, t);
    pop_chk((t < 0) ? -1 : t - g);
    chk("glitch_retry", 32'(RETRY_CNT), 32'd1);

    // DCM fault while running
    tick();
    DCM_STATUS = 1'b1;
    f = cyc;
    expect_val("status_loss_lat", 3);
    wait_lvl(1, 1'b0, 10, t);
    pop_chk((t < 0) ? -1 : t - f);
    chk("status_retry", 32'(RETRY_CNT), 32'd2);
    DCM_STATUS = 1'b0;

    // Lock never arrives: periodic re-reset and saturating retry count
    RST_n = 1'b0;
    DCM_LOCKED = 1'b0;
    repeat (2) tick();
    RST_n = 1'b1;
    prev = cyc;
    for (int n = 1; n <= 16; n++) begin
      wait_lvl(0, 1'b0, 10, t);
      wait_lvl(0, 1'b1, LOCK_TIMEOUT + RST_CYCLES + 10, t);
      expect_val("timeout_period", LOCK_TIMEOUT + RST_CYCLES);
      expect_val("timeout_retry", (n < 15) ? n : 15);
      pop_chk((t < 0 || prev < 0) ? -1 : t - prev);
      pop_chk(32'(RETRY_CNT));
      prev = t;
    end

    chk("sb_drained", 32'(sb_val.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
